// File: rtl/scan_codes_pkg.sv
// Scan-code constants for the PS/2 Set-2 digit keys and the default break prefix.
// Keypad constants are always defined; only scan_digit_lut decides whether they
// decode (controlled by SCAN_CODES_KEYPAD_EN).
package scan_codes_pkg;

    localparam logic [7:0] BREAK_PREFIX_DEFAULT = 8'hF0;

    // Top-row digit keys
    localparam logic [7:0] SC_KEY_0 = 8'h45;
    localparam logic [7:0] SC_KEY_1 = 8'h16;
    localparam logic [7:0] SC_KEY_2 = 8'h1E;
    localparam logic [7:0] SC_KEY_3 = 8'h26;
    localparam logic [7:0] SC_KEY_4 = 8'h25;
    localparam logic [7:0] SC_KEY_5 = 8'h2E;
    localparam logic [7:0] SC_KEY_6 = 8'h36;
    localparam logic [7:0] SC_KEY_7 = 8'h3D;
    localparam logic [7:0] SC_KEY_8 = 8'h3E;
    localparam logic [7:0] SC_KEY_9 = 8'h46;

    // Numeric keypad digit keys
    localparam logic [7:0] SC_KP_0 = 8'h70;
    localparam logic [7:0] SC_KP_1 = 8'h69;
    localparam logic [7:0] SC_KP_2 = 8'h72;
    localparam logic [7:0] SC_KP_3 = 8'h7A;
    localparam logic [7:0] SC_KP_4 = 8'h6B;
    localparam logic [7:0] SC_KP_5 = 8'h73;
    localparam logic [7:0] SC_KP_6 = 8'h74;
    localparam logic [7:0] SC_KP_7 = 8'h6C;
    localparam logic [7:0] SC_KP_8 = 8'h75;
    localparam logic [7:0] SC_KP_9 = 8'h7D;

endpackage

// File: rtl/scan_digit_lut.sv
// Combinational scan-code to digit lookup.
// Optional macro SCAN_CODES_KEYPAD_EN adds the numeric-keypad entries.
module scan_digit_lut
    import scan_codes_pkg::*;
(
    input  logic [7:0] scan,
    output logic       hit,
    output logic [3:0] digit
);

    // Map a scan code to its digit; hit=0 for anything not in the table.
    always_comb begin
        hit   = 1'b1;
        digit = 4'd0;
        case (scan)
            SC_KEY_0: digit = 4'd0;
            SC_KEY_1: digit = 4'd1;
            SC_KEY_2: digit = 4'd2;
            SC_KEY_3: digit = 4'd3;
            SC_KEY_4: digit = 4'd4;
            SC_KEY_5: digit = 4'd5;
            SC_KEY_6: digit = 4'd6;
            SC_KEY_7: digit = 4'd7;
            SC_KEY_8: digit = 4'd8;
            SC_KEY_9: digit = 4'd9;
`ifdef SCAN_CODES_KEYPAD_EN
            SC_KP_0:  digit = 4'd0;
            SC_KP_1:  digit = 4'd1;
            SC_KP_2:  digit = 4'd2;
            SC_KP_3:  digit = 4'd3;
            SC_KP_4:  digit = 4'd4;
            SC_KP_5:  digit = 4'd5;
            SC_KP_6:  digit = 4'd6;
            SC_KP_7:  digit = 4'd7;
            SC_KP_8:  digit = 4'd8;
            SC_KP_9:  digit = 4'd9;
`endif
            default:  hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/scan_codes.sv
// PS/2 Set-2 digit-key release decoder.
// Optional macro SCAN_CODES_KEYPAD_EN (in scan_digit_lut) enables keypad digits.
//
// Input qualification: status is a valid strobe for code, with no ready/back-
// pressure. Every rising edge with status=1 evaluates code on its own; a held
// status therefore yields one evaluation per cycle.
module scan_codes
    import scan_codes_pkg::*;
#(
    parameter logic [7:0] BREAK_PREFIX = BREAK_PREFIX_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] code,
    input  logic        status,
    output logic        control,
    output logic [3:0]  num
);

    logic       lut_hit;
    logic [3:0] lut_digit;
    logic       control_d, control_q;
    logic [3:0] num_d, num_q;

    scan_digit_lut u_lut (
        .scan  (code[7:0]),
        .hit   (lut_hit),
        .digit (lut_digit)
    );

    // Accept only a qualified break sequence of a known digit; otherwise num holds.
    always_comb begin
        control_d = 1'b0;
        num_d     = num_q;
        if (status && (code[15:8] == BREAK_PREFIX) && lut_hit) begin
            control_d = 1'b1;
            num_d     = lut_digit;
        end
    end

    // Output registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            control_q <= 1'b0;
            num_q     <= 4'd0;
        end else begin
            control_q <= control_d;
            num_q     <= num_d;
        end
    end

    assign control = control_q;
    assign num     = num_q;

endmodule

// File: tb/tb_scan_codes.sv
// Testbench for scan_codes: directed sequences plus random traffic, checked by
// a scoreboard queue fed from an independent table-driven reference model.
module tb_scan_codes;

    logic        clk;
    logic        rst;
    logic [15:0] code;
    logic        status;
    logic        control;
    logic [3:0]  num;

    scan_codes dut (
        .clk     (clk),
        .rst     (rst),
        .code    (code),
        .status  (status),
        .control (control),
        .num     (num)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference tables, indexed by digit
    logic [7:0] top_tab [10];
    logic [7:0] kp_tab  [10];
    initial begin
        top_tab = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
        kp_tab  = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};
    end

    // Scoreboard: {control, num}
    logic [4:0] exp_q [$];
    logic [3:0] model_num;
    int         n_cmp;
    int         n_err;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: returns {hit, digit} for a 16-bit code
    function automatic logic [4:0] ref_decode(input logic [15:0] c);
        logic [4:0] r;
        r = 5'd0;
        if (c[15:8] == 8'hF0) begin
            for (int i = 0; i < 10; i++) begin
                if (c[7:0] == top_tab[i]) r = {1'b1, 4'(i)};
`ifdef SCAN_CODES_KEYPAD_EN
                if (c[7:0] == kp_tab[i]) r = {1'b1, 4'(i)};
`endif
            end
        end
        return r;
    endfunction

    // Driver: apply one cycle of inputs, push expectation, compare after the edge
    task automatic step(input logic r, input logic s, input logic [15:0] c, input string tag);
        logic [4:0] d;
        logic [4:0] e;
        @(negedge clk);
        rst    = r;
        status = s;
        code   = c;
        d = ref_decode(c);
        if (r) begin
            model_num = 4'd0;
            exp_q.push_back(5'd0);
        end else if (s && d[4]) begin
            model_num = d[3:0];
            exp_q.push_back({1'b1, d[3:0]});
        end else begin
            exp_q.push_back({1'b0, model_num});
        end
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 8'd1, 8'd0);
        end else begin
            e = exp_q.pop_front();
            check_eq({tag, "_control"}, {7'd0, control}, {7'd0, e[4]});
            check_eq({tag, "_num"}, {4'd0, num}, {4'd0, e[3:0]});
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        model_num = 4'd0;
        rst       = 1'b1;
        status    = 1'b0;
        code      = 16'h0000;

        // Reset held for two edges, then released idle
        step(1'b1, 1'b0, 16'h0000, "reset0");
        step(1'b1, 1'b0, 16'h0000, "reset1");
        step(1'b0, 1'b0, 16'h0000, "idle_after_reset");

        // Full top-row mapping sweep, each followed by an idle cycle
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 1'b1, {8'hF0, top_tab[i % 10]}, "sweep");
            step(1'b0, 1'b0, 16'h0000, "sweep_idle");
        end

        // Rejects after a known digit (5)
        step(1'b0, 1'b1, 16'hF02E, "set5");
        step(1'b0, 1'b1, 16'hF01C, "rej_unknown");
        step(1'b0, 1'b1, 16'h0016, "rej_make");
        step(1'b0, 1'b1, 16'hE016, "rej_e0");
        step(1'b0, 1'b1, 16'h0000, "rej_zero");

        // Qualification: valid code without status does nothing
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'hF036, "qual_low");
        step(1'b0, 1'b1, 16'hF036, "qual_high");

        // Sustained status and back-to-back codes
        step(1'b0, 1'b1, 16'hF03D, "hold0");
        step(1'b0, 1'b1, 16'hF03D, "hold1");
        step(1'b0, 1'b1, 16'hF045, "b2b0");
        step(1'b0, 1'b1, 16'hF016, "b2b1");

        // Reset mid-stream wins over a valid code
        step(1'b0, 1'b1, 16'hF046, "set9");
        step(1'b1, 1'b1, 16'hF016, "rst_mid");
        step(1'b0, 1'b0, 16'h0000, "after_rst_mid");

        // Keypad codes (decode only when the feature is built in)
        step(1'b0, 1'b1, 16'hF03E, "set8");
        step(1'b0, 1'b1, 16'hF070, "kp0");
        step(1'b0, 1'b1, 16'hF07D, "kp9");
        step(1'b0, 1'b0, 16'h0000, "kp_idle");

        // Random traffic mixing valid, keypad and junk codes
        for (int i = 0; i < 200; i++) begin
            logic [15:0] c;
            logic        s;
            logic        r;
            int          sel;
            sel = $urandom_range(0, 3);
            case (sel)
                0:       c = {8'hF0, top_tab[$urandom_range(0, 9)]};
                1:       c = {8'hF0, kp_tab[$urandom_range(0, 9)]};
                2:       c = {8'hF0, 8'($urandom_range(0, 255))};
                default: c = 16'($urandom_range(0, 65535));
            endcase
            s = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 31) == 0);
            step(r, s, c, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
